// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 responder: widths, command and response codes, FSM states.
package calc1_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [0:CMD_W-1] CMD_NOP = 4'd0;
  localparam logic [0:CMD_W-1] CMD_ADD = 4'd1;
  localparam logic [0:CMD_W-1] CMD_SUB = 4'd2;
  localparam logic [0:CMD_W-1] CMD_SHL = 4'd5;
  localparam logic [0:CMD_W-1] CMD_SHR = 4'd6;

  localparam logic [0:RESP_W-1] RESP_NONE = 2'd0;
  localparam logic [0:RESP_W-1] RESP_OK   = 2'd1;
  localparam logic [0:RESP_W-1] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPND2 = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

endpackage

// File: rtl/calc1_port_alu.sv
// Combinational calc1 datapath: add/sub with range check, logical shifts, invalid-command decode.
module calc1_port_alu
  import calc1_pkg::*;
(
  input  logic [0:DATA_W-1] op1,
  input  logic [0:DATA_W-1] op2,
  input  logic [0:CMD_W-1]  cmd,
  output logic [0:DATA_W-1] result,
  output logic [0:RESP_W-1] resp
);

  logic [DATA_W:0] sum;
  logic [0:4]      shamt;

  assign sum   = {1'b0, op1} + {1'b0, op2};
  // Only the low five bits of operand 2 select the shift distance.
  assign shamt = op2[DATA_W-5:DATA_W-1];

  always_comb begin
    // NOTE: outputs get a default before the case so no path can infer a latch.
    result = '0;
    resp   = RESP_ERR;
    case (cmd)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          result = sum[DATA_W-1:0];
          resp   = RESP_OK;
        end
      end
      CMD_SUB: begin
        if (op1 >= op2) begin
          result = op1 - op2;
          resp   = RESP_OK;
        end
      end
      CMD_SHL: begin
        result = op1 << shamt;
        resp   = RESP_OK;
      end
      CMD_SHR: begin
        result = op1 >> shamt;
        resp   = RESP_OK;
      end
      default: begin
        result = '0;
        resp   = RESP_ERR;
      end
    endcase
  end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1 responder: command/operand capture FSM, execute counter and one-cycle response registers.
// Optional sticky protocol checker enabled by defining CALC1_PROTO_CHECK_EN.
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [0:CMD_W-1]  req_cmd_in,
  input  logic [0:DATA_W-1] req_data_in,
  output logic [0:RESP_W-1] out_resp,
  output logic [0:DATA_W-1] out_data,
  output logic              busy
`ifdef CALC1_PROTO_CHECK_EN
  ,
  output logic              proto_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [0:CMD_W-1]  cmd_q;
  logic [0:DATA_W-1] op1_q;
  logic [0:DATA_W-1] op2_q;
  logic [0:DATA_W-1] alu_result;
  logic [0:RESP_W-1] alu_resp;

  calc1_port_alu u_alu (
    .op1    (op1_q),
    .op2    (op2_q),
    .cmd    (cmd_q),
    .result (alu_result),
    .resp   (alu_resp)
  );

  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cmd_q    <= CMD_NOP;
      op1_q    <= '0;
      op2_q    <= '0;
      out_resp <= RESP_NONE;
      out_data <= '0;
      busy     <= 1'b0;
    end else begin
      // A loaded response lives for one cycle unless overwritten below.
      out_resp <= RESP_NONE;
      out_data <= '0;
      case (state)
        ST_IDLE: begin
          if (req_cmd_in != CMD_NOP) begin
            cmd_q <= req_cmd_in;
            op1_q <= req_data_in;
            busy  <= 1'b1;
            state <= ST_OPND2;
          end
        end
        ST_OPND2: begin
          op2_q <= req_data_in;
          cnt   <= CNT_LOAD;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            out_resp <= alu_resp;
            out_data <= alu_result;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CALC1_PROTO_CHECK_EN
  // Commands are never queued; any attempt while busy is latched until reset.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (busy && (req_cmd_in != CMD_NOP)) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_calc1_port_responder.sv
// Self-checking bench for calc1_port_responder: directed corner cases plus a random command stream.
module tb_calc1_port_responder;

  localparam int L = 2;

  logic        c_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_cmd_in = 4'd0;
  logic [31:0] req_data_in = 32'd0;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        busy;
`ifdef CALC1_PROTO_CHECK_EN
  logic        proto_err;
`endif

  calc1_port_responder #(.LATENCY(L)) dut (
    .c_clk       (c_clk),
    .reset_n     (reset_n),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy)
`ifdef CALC1_PROTO_CHECK_EN
    ,
    .proto_err   (proto_err)
`endif
  );

  always #5 c_clk = ~c_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: one command in flight, timed in clock edges.
  int          cyc_edge = 0;
  bit          m_active = 0;
  int          m_accept = 0;
  logic [3:0]  m_cmd = 4'd0;
  logic [31:0] m_op1 = 32'd0;
  logic [1:0]  m_resp = 2'd0;
  logic [31:0] m_data = 32'd0;
  bit          m_proto = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] ref_calc(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] s;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      end
      4'd2:    return (a < b) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5:    return {2'd1, a << b[4:0]};
      4'd6:    return {2'd1, a >> b[4:0]};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  // Present inputs for the next edge, advance the model, then compare just after that edge.
  task automatic step(input logic [3:0] cmd, input logic [31:0] data);
    logic [1:0]  er;
    logic [31:0] ed;
    req_cmd_in  = cmd;
    req_data_in = data;
    er = 2'd0;
    ed = 32'd0;
    if (!reset_n) begin
      m_active = 0;
      m_proto  = 0;
    end else if (m_active) begin
      if (cmd != 4'd0) m_proto = 1;
      if (cyc_edge == m_accept + 1) {m_resp, m_data} = ref_calc(m_cmd, m_op1, data);
      if (cyc_edge == m_accept + 1 + L) begin
        er = m_resp;
        ed = m_data;
        m_active = 0;
      end
    end else if (cmd != 4'd0) begin
      m_active = 1;
      m_accept = cyc_edge;
      m_cmd    = cmd;
      m_op1    = data;
    end
    @(posedge c_clk);
    #1;
    check($sformatf("resp@%0d", cyc_edge), 32'(out_resp), 32'(er));
    check($sformatf("data@%0d", cyc_edge), out_data, ed);
    check($sformatf("busy@%0d", cyc_edge), 32'(busy), 32'(m_active));
`ifdef CALC1_PROTO_CHECK_EN
    check($sformatf("proto@%0d", cyc_edge), 32'(proto_err), 32'(m_proto));
`endif
    cyc_edge++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, $urandom);
  endtask

  // Command cycle, operand-2 cycle, latency, response cycle and one clear cycle.
  task automatic run_cmd(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    step(c, a);
    step(4'd0, b);
    idle(L + 1);
  endtask

  // Reset asserted between edges: outputs must drop without waiting for a clock.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    m_active = 0;
    m_proto  = 0;
    #1;
    check({tag, "_resp"}, 32'(out_resp), 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef CALC1_PROTO_CHECK_EN
    check({tag, "_proto"}, 32'(proto_err), 32'd0);
`endif
  endtask

  initial begin
    async_reset("por");
    idle(4);
    reset_n = 1'b1;
    idle(5);

    run_cmd(4'd1, 32'd1, 32'h1FFF_FFFF);
    run_cmd(4'd1, 32'hFFFF_FFFF, 32'd1);
    run_cmd(4'd2, 32'd1, 32'hF);
    run_cmd(4'd2, 32'h10, 32'h10);
    run_cmd(4'd5, 32'd1, 32'd31);
    run_cmd(4'd6, 32'h8000_0000, 32'h21);
    run_cmd(4'd3, 32'h1234_5678, 32'd1);
    run_cmd(4'd4, 32'h1234_5678, 32'd1);
    run_cmd(4'd15, 32'hDEAD_BEEF, 32'd7);

    // Command while busy: ignored, no extra response.
    step(4'd1, 32'd100);
    step(4'd0, 32'd23);
    step(4'd1, 32'd5);
    idle(L + 3);

    // Back-to-back: second command presented in the response cycle.
    step(4'd1, 32'd7);
    step(4'd0, 32'd8);
    idle(L);
    step(4'd2, 32'd50);
    step(4'd0, 32'd8);
    idle(L + 2);

    // Reset during EXEC aborts the command.
    step(4'd1, 32'd3);
    step(4'd0, 32'd4);
    async_reset("rst_exec");
    idle(2);
    reset_n = 1'b1;
    idle(L + 4);

    // Reset in the response cycle clears the response at once.
    step(4'd5, 32'd3);
    step(4'd0, 32'd4);
    idle(L);
    async_reset("rst_resp");
    idle(1);
    reset_n = 1'b1;
    idle(3);

    // Random stream, including invalid codes and commands issued while busy.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  c;
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       c = 4'($urandom_range(0, 15));
        1:       c = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
        default: c = 4'd0;
      endcase
      case ($urandom_range(0, 5))
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'($urandom_range(0, 40));
        default: d = $urandom;
      endcase
      step(c, d);
      if (i == 700) begin
        async_reset("rst_rand");
        idle(2);
        reset_n = 1'b1;
      end
    end
    idle(L + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
